// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
//
// Round-robin AHB bus arbiter for 16 masters with burst and locked-transfer
// awareness. The grant is a registered one-hot vector. The address-phase
// owner (hmaster) follows the grant by one hready edge.
//
// Parameters
//   DEFAULT_MASTER  index of the master parked on the bus when nobody requests
//
// Ports
//   hclk       in   bus clock, rising edge
//   hreset     in   synchronous active-high reset
//   hbusreq    in   [15:0] bus requests, one bit per master
//   hlock      in   [15:0] locked-transfer requests, one bit per master
//   htrans     in   [1:0]  transfer type of the current address-phase owner
//   hburst     in   [2:0]  burst type of the current address-phase owner
//   hready     in   transfer complete; all arbitration state advances only on it
//   hgrant     out  [15:0] one-hot grant
//   hmaster    out  [3:0]  index of the address-phase owner
//   hmastlock  out  current address-phase transfer is locked
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [15:0] hbusreq,
    input  logic [15:0] hlock,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic        hready,
    output logic [15:0] hgrant,
    output logic [3:0]  hmaster,
    output logic        hmastlock
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [3:0]  DEF_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [15:0] DEF_GRANT = 16'(1) << DEF_IDX;

    logic [3:0]  gidx_q, gidx_d;
    logic [3:0]  hmaster_q;
    logic        hmastlock_q;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [15:0] hgrant_q, hgrant_d;

    logic        open_w;
    logic [15:0] rot_req;
    logic [3:0]  pick_off;
    logic [3:0]  winner;

    // Beats still owed after the transfer completing on this edge. The
    // arbiter looks at this post-beat count so that a burst's own NONSEQ
    // already blocks rearbitration, and the final SEQ (or an aborting IDLE)
    // releases the bus on the same edge.
    always_comb begin
        bcnt_d = bcnt_q;
        case (htrans)
            HTRANS_IDLE: bcnt_d = 4'd0;
            HTRANS_BUSY: bcnt_d = bcnt_q;
            HTRANS_NONSEQ: begin
                case (hburst)
                    3'b010, 3'b011: bcnt_d = 4'd3;
                    3'b100, 3'b101: bcnt_d = 4'd7;
                    3'b110, 3'b111: bcnt_d = 4'd15;
                    default:        bcnt_d = 4'd0;
                endcase
            end
            HTRANS_SEQ: bcnt_d = (bcnt_q != 4'd0) ? bcnt_q - 4'd1 : 4'd0;
            default:    bcnt_d = bcnt_q;
        endcase
    end

    assign open_w = (bcnt_d == 4'd0) && !hlock[gidx_q] && !hmastlock_q;

    // Requests rotated so bit 0 is the master just after the current owner;
    // bit 15 is the owner itself, giving it lowest priority.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            assign rot_req[gi] = hbusreq[4'(gidx_q + 4'(gi + 1))];
        end
    endgenerate

    always_comb begin
        pick_off = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off = 4'(k);
            end
        end
    end

    assign winner = gidx_q + 4'd1 + pick_off;

    always_comb begin
        gidx_d = gidx_q;
        if (hready && open_w) begin
            gidx_d = (|hbusreq) ? winner : DEF_IDX;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign hgrant_d[gi] = (gidx_d == 4'(gi));
        end
    endgenerate

    always_ff @(posedge hclk) begin
        if (hreset) begin
            gidx_q      <= DEF_IDX;
            hgrant_q    <= DEF_GRANT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            bcnt_q      <= 4'd0;
        end else begin
            gidx_q   <= gidx_d;
            hgrant_q <= hgrant_d;
            if (hready) begin
                // Ownership and lock follow the grant as it stood before this edge.
                hmaster_q   <= gidx_q;
                hmastlock_q <= hlock[gidx_q];
                bcnt_q      <= bcnt_d;
            end
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;

    localparam int DM = 0;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [15:0] hbusreq;
    logic [15:0] hlock;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic        hready;
    logic [15:0] hgrant;
    logic [3:0]  hmaster;
    logic        hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers)
    int m_owner   = DM;   // granted master
    int m_addr    = DM;   // address-phase owner
    int m_locked  = 0;
    int m_left    = 0;    // beats still owed in the current burst
    bit m_valid   = 1'b0;

    ahb_rr_arbiter #(.DEFAULT_MASTER(DM)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    // Beats remaining once the current transfer completes.
    function automatic int beats_after(int left, logic [1:0] t, logic [2:0] b);
        int len;
        case (t)
            2'b00: return 0;
            2'b01: return left;
            2'b10: begin
                if (b < 3'd2) len = 1;
                else          len = 4 << (int'(b >> 1) - 1);
                return len - 1;
            end
            default: return (left > 0) ? left - 1 : 0;
        endcase
    endfunction

    // Model: advances on each rising edge from the spec's rules.
    initial begin
        int after;
        int next_owner;
        bit is_open;
        forever begin
            @(posedge hclk);
            if (hreset) begin
                m_owner  = DM;
                m_addr   = DM;
                m_locked = 0;
                m_left   = 0;
                m_valid  = 1'b1;
            end else if (hready) begin
                after = beats_after(m_left, htrans, hburst);
                is_open = (after == 0) && (hlock[m_owner] == 1'b0) && (m_locked == 0);
                next_owner = m_owner;
                if (is_open) begin
                    if (hbusreq == 16'h0) begin
                        next_owner = DM;
                    end else begin
                        for (int k = 1; k <= 16; k++) begin
                            if (hbusreq[(m_owner + k) % 16]) begin
                                next_owner = (m_owner + k) % 16;
                                break;
                            end
                        end
                    end
                end
                m_addr   = m_owner;
                m_locked = int'(hlock[m_owner]);
                m_left   = after;
                m_owner  = next_owner;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        logic [15:0] exp_g;
        forever begin
            @(negedge hclk);
            if (m_valid) begin
                exp_g = 16'h0001 << m_owner;
                n_checks++;
                if (hgrant !== exp_g || hmaster !== 4'(m_addr) || hmastlock !== 1'(m_locked)) begin
                    n_errors++;
                    $display("FAIL model t=%0t: hgrant=%h hmaster=%0d hmastlock=%0b, required %h %0d %0b",
                             $time, hgrant, hmaster, hmastlock, exp_g, m_addr, m_locked);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic expect3(string tag, logic [15:0] g, logic [3:0] m, logic ml);
        n_checks++;
        if (hgrant !== g || hmaster !== m || hmastlock !== ml) begin
            n_errors++;
            $display("FAIL %s: hgrant=%h hmaster=%0d hmastlock=%0b, required %h %0d %0b",
                     tag, hgrant, hmaster, hmastlock, g, m, ml);
        end else begin
            $display("ok   %s: hgrant=%h hmaster=%0d hmastlock=%0b", tag, hgrant, hmaster, hmastlock);
        end
    endtask

    initial begin
        hreset  = 1'b1;
        hbusreq = 16'h0;
        hlock   = 16'h0;
        htrans  = 2'b00;
        hburst  = 3'b000;
        hready  = 1'b1;
        tick();
        tick();
        expect3("reset", 16'h0001, 4'd0, 1'b0);
        hreset = 1'b0;

        // Idle bus parks on the default master
        for (int i = 0; i < 10; i++) begin
            tick();
            expect3("park", 16'h0001, 4'd0, 1'b0);
        end

        // Rotation between masters 16 and 1
        hbusreq = 16'h8001;
        tick(); expect3("rot1", 16'h8000, 4'd0, 1'b0);
        tick(); expect3("rot2", 16'h0001, 4'd15, 1'b0);
        tick(); expect3("rot3", 16'h8000, 4'd0, 1'b0);
        hbusreq = 16'h0;
        tick(); expect3("repark", 16'h0001, 4'd15, 1'b0);
        tick(); expect3("repark2", 16'h0001, 4'd0, 1'b0);

        // INCR8 burst by index 2 with a competing request and wait states
        hbusreq = 16'h0004;
        tick(); expect3("b8_grant", 16'h0004, 4'd0, 1'b0);
        tick(); expect3("b8_own", 16'h0004, 4'd2, 1'b0);
        hbusreq = 16'h0006;
        htrans  = 2'b10;
        hburst  = 3'b101;
        tick(); expect3("b8_nonseq", 16'h0004, 4'd2, 1'b0);
        htrans = 2'b11;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                hready = 1'b0;
                tick();
                tick();
                expect3("b8_wait", 16'h0004, 4'd2, 1'b0);
                hready = 1'b1;
            end
            tick();
            if (i < 6) expect3("b8_seq", 16'h0004, 4'd2, 1'b0);
            else       expect3("b8_end", 16'h0002, 4'd2, 1'b0);
        end
        htrans  = 2'b00;
        hbusreq = 16'h0;
        tick(); expect3("b8_after", 16'h0001, 4'd1, 1'b0);

        // Locked transfers by index 4 against all requesters
        hbusreq = 16'h0010;
        hlock   = 16'h0010;
        tick(); expect3("lk_grant", 16'h0010, 4'd0, 1'b0);
        tick(); expect3("lk_own", 16'h0010, 4'd4, 1'b1);
        hbusreq = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect3("lk_hold", 16'h0010, 4'd4, 1'b1);
        end
        hlock = 16'h0;
        tick(); expect3("lk_tail", 16'h0010, 4'd4, 1'b0);
        tick(); expect3("lk_move", 16'h0020, 4'd4, 1'b0);

        // INCR16 aborted by IDLE after four SEQ beats
        hbusreq = 16'h0020;
        tick(); expect3("ab_own", 16'h0020, 4'd5, 1'b0);
        hbusreq = 16'h0021;
        htrans  = 2'b10;
        hburst  = 3'b111;
        tick(); expect3("ab_nonseq", 16'h0020, 4'd5, 1'b0);
        htrans = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect3("ab_seq", 16'h0020, 4'd5, 1'b0);
        end
        htrans = 2'b00;
        tick(); expect3("ab_idle", 16'h0001, 4'd5, 1'b0);

        // Reset in the middle of a locked INCR4
        hbusreq = 16'h0002;
        tick(); expect3("rs_grant", 16'h0002, 4'd0, 1'b0);
        tick(); expect3("rs_own", 16'h0002, 4'd1, 1'b0);
        hbusreq = 16'h0003;
        hlock   = 16'h0002;
        htrans  = 2'b10;
        hburst  = 3'b011;
        tick(); expect3("rs_nonseq", 16'h0002, 4'd1, 1'b1);
        htrans = 2'b11;
        tick(); expect3("rs_seq", 16'h0002, 4'd1, 1'b1);
        hreset = 1'b1;
        tick(); expect3("rs_reset", 16'h0001, 4'd0, 1'b0);
        hreset  = 1'b0;
        hlock   = 16'h0;
        htrans  = 2'b00;
        hbusreq = 16'h0002;
        tick(); expect3("rs_first", 16'h0002, 4'd0, 1'b0);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 300; i++) begin
            hbusreq = 16'($urandom);
            hlock   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            htrans  = 2'($urandom);
            hburst  = 3'($urandom);
            hready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
